// File: rtl/arm_mem_pkg.sv
// Shared types and defaults for the ARM pipeline's SRAM port arbiter.
package arm_mem_pkg;

    localparam int WAIT_CYCLES_DEF = 2;
    localparam int ADDR_W_DEF      = 18;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DATA    = 2'd1,
        INST    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter that times one SRAM access; zero marks the final access cycle.
module mem_wait_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF-stage fetches and MEM-stage data accesses onto one fixed-latency
// single-ported SRAM; data accesses win over fetches, and nothing is preempted.
module mem_port_arbiter
    import arm_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int ADDR_W      = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    input  logic              if_flush,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    output logic              if_stall,
    input  logic              mem_rd_en,
    input  logic              mem_wr_en,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_ready,
    output logic              pipe_freeze,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output state_t            fsm_state
);

    localparam int CW = $clog2(WAIT_CYCLES) + 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(WAIT_CYCLES - 1);

    // Handshake: each requester holds its request level until its one-cycle ready
    // pulse; during that ready cycle the request is masked so it is never granted twice.
    state_t state;
    state_t next_state;
    op_t    op_q;
    logic   data_req;
    logic   fetch_req;
    logic   grant_data;
    logic   grant_inst;
    logic   done;
    logic   cnt_zero;
    logic   unused_addr_bits;

    assign data_req  = (mem_rd_en | mem_wr_en) & ~mem_ready;
    assign fetch_req = if_req & ~if_ready & ~if_flush;

    assign if_stall    = if_req & ~if_ready;
    assign pipe_freeze = (mem_rd_en | mem_wr_en) & ~mem_ready;
    assign fsm_state   = state;

    assign unused_addr_bits = ^{if_addr[1:0], if_addr[31:ADDR_W+2],
                                mem_addr[1:0], mem_addr[31:ADDR_W+2]};

    mem_wait_counter #(.WIDTH(CW)) u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (grant_data | grant_inst),
        .load_val (LOAD_VAL),
        .dec      (state != IDLE),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        grant_data = 1'b0;
        grant_inst = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (data_req) begin
                    next_state = DATA;
                    grant_data = 1'b1;
                end else if (fetch_req) begin
                    next_state = INST;
                    grant_inst = 1'b1;
                end
            end
            DATA, DISCARD: begin
                if (cnt_zero) begin
                    next_state = IDLE;
                    done       = 1'b1;
                end
            end
            INST: begin
                // A flush on the final cycle still ends the access; only the ready is dropped.
                if (cnt_zero) begin
                    next_state = IDLE;
                    done       = 1'b1;
                end else if (if_flush) begin
                    next_state = DISCARD;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            op_q       <= OP_RD;
            if_ready   <= 1'b0;
            mem_ready  <= 1'b0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
        end else begin
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            if (grant_data) begin
                // Both enables together count as a store.
                sram_addr  <= mem_addr[ADDR_W+1:2];
                sram_wdata <= mem_wdata;
                op_q       <= mem_wr_en ? OP_WR : OP_RD;
                sram_we_n  <= ~mem_wr_en;
                sram_oe_n  <= mem_wr_en;
            end else if (grant_inst) begin
                sram_addr <= if_addr[ADDR_W+1:2];
                op_q      <= OP_RD;
                sram_we_n <= 1'b1;
                sram_oe_n <= 1'b0;
            end else if (done) begin
                sram_we_n <= 1'b1;
                sram_oe_n <= 1'b1;
                if (state == DATA) begin
                    mem_ready <= 1'b1;
                    if (op_q == OP_RD) begin
                        mem_rdata <= sram_rdata;
                    end
                end
                if ((state == INST) && !if_flush) begin
                    if_ready <= 1'b1;
                    if_rdata <= sram_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at WAIT_CYCLES=2, one at 1 for the alternating sweep.
module tb_mem_port_arbiter;
    import arm_mem_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        if_req, if_flush, mem_rd_en, mem_wr_en;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [31:0] if_rdata, mem_rdata, sram_wdata, sram_rdata;
    logic        if_ready, if_stall, mem_ready, pipe_freeze, sram_we_n, sram_oe_n;
    logic [17:0] sram_addr;
    state_t      fsm_state;
    logic [31:0] sram_mem [0:255];

    logic        b_if_req, b_if_flush, b_mem_rd_en, b_mem_wr_en;
    logic [31:0] b_if_addr, b_mem_addr, b_mem_wdata;
    logic [31:0] b_if_rdata, b_mem_rdata, b_sram_wdata, b_sram_rdata;
    logic        b_if_ready, b_if_stall, b_mem_ready, b_pipe_freeze, b_sram_we_n, b_sram_oe_n;
    logic [17:0] b_sram_addr;
    state_t      b_fsm_state;

    logic [31:0] d_exp_q[$];
    logic [31:0] i_exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    mem_port_arbiter #(.WAIT_CYCLES(2), .ADDR_W(18)) u_dut_a (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_ready(if_ready), .if_stall(if_stall),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pipe_freeze(pipe_freeze), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
        .fsm_state(fsm_state)
    );

    mem_port_arbiter #(.WAIT_CYCLES(1), .ADDR_W(18)) u_dut_b (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_flush(b_if_flush),
        .if_rdata(b_if_rdata), .if_ready(b_if_ready), .if_stall(b_if_stall),
        .mem_rd_en(b_mem_rd_en), .mem_wr_en(b_mem_wr_en), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .mem_ready(b_mem_ready),
        .pipe_freeze(b_pipe_freeze), .sram_addr(b_sram_addr), .sram_wdata(b_sram_wdata),
        .sram_rdata(b_sram_rdata), .sram_we_n(b_sram_we_n), .sram_oe_n(b_sram_oe_n),
        .fsm_state(b_fsm_state)
    );

    // SRAM models: A is a real read/write array, B returns a word derived from its address.
    assign sram_rdata = sram_oe_n ? 32'h0 : sram_mem[sram_addr[7:0]];
    always @(posedge clk) begin
        if (!sram_we_n) sram_mem[sram_addr[7:0]] <= sram_wdata;
    end
    assign b_sram_rdata = b_sram_oe_n ? 32'h0 : {14'h2B0B, b_sram_addr};

    function automatic logic [31:0] b_word(input logic [31:0] byte_addr);
        return {14'h2B0B, byte_addr[19:2]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Issue one data access on DUT A from an idle cycle; returns data and request-to-ready latency.
    task automatic a_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output int lat);
        mem_wr_en = wr;
        mem_rd_en = ~wr;
        mem_addr  = addr;
        mem_wdata = wdata;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!mem_ready && lat < 10);
        if (!mem_ready) check("a_access_timeout", 32'(mem_ready), 32'd1);
        rdata = mem_rdata;
        mem_wr_en = 1'b0;
        mem_rd_en = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int lat;
        int d_done, i_done, last, extra;

        rst = 1'b0;
        {if_req, if_flush, mem_rd_en, mem_wr_en} = '0;
        if_addr = '0; mem_addr = '0; mem_wdata = '0;
        {b_if_req, b_if_flush, b_mem_rd_en, b_mem_wr_en} = '0;
        b_if_addr = '0; b_mem_addr = '0; b_mem_wdata = '0;

        repeat (2) tick();
        check("rst_if_ready",  32'(if_ready),  32'd0);
        check("rst_mem_ready", 32'(mem_ready), 32'd0);
        check("rst_we_n",      32'(sram_we_n), 32'd1);
        check("rst_oe_n",      32'(sram_oe_n), 32'd1);
        check("rst_sram_addr", 32'(sram_addr), 32'd0);
        check("rst_if_rdata",  if_rdata,       32'd0);
        check("rst_mem_rdata", mem_rdata,      32'd0);
        check("rst_state",     32'(fsm_state), 32'(IDLE));
        rst = 1'b1;
        tick();

        // Store with per-cycle checks
        mem_wr_en = 1'b1; mem_addr = 32'h100; mem_wdata = 32'hDEAD_BEEF;
        #1 check("st_freeze_c0", 32'(pipe_freeze), 32'd1);
        tick();
        check("st_we_n_c1",   32'(sram_we_n),  32'd0);
        check("st_oe_n_c1",   32'(sram_oe_n),  32'd1);
        check("st_addr_c1",   32'(sram_addr),  32'h40);
        check("st_wdata_c1",  sram_wdata,      32'hDEAD_BEEF);
        check("st_state_c1",  32'(fsm_state),  32'(DATA));
        tick();
        check("st_we_n_c2",   32'(sram_we_n),  32'd0);
        check("st_freeze_c2", 32'(pipe_freeze), 32'd1);
        tick();
        check("st_ready_c3",  32'(mem_ready),  32'd1);
        check("st_freeze_c3", 32'(pipe_freeze), 32'd0);
        check("st_we_n_c3",   32'(sram_we_n),  32'd1);
        mem_wr_en = 1'b0;
        tick();
        check("st_ready_c4",  32'(mem_ready),  32'd0);

        a_access(1'b1, 32'h10,  32'hE3A0_0001, rd, lat);
        a_access(1'b1, 32'h104, 32'h1234_5678, rd, lat);
        a_access(1'b0, 32'h100, 32'h0, rd, lat);
        check("ld_data", rd, 32'hDEAD_BEEF);
        check("ld_lat",  32'(lat), 32'd3);

        // Fetch
        if_req = 1'b1; if_addr = 32'h10;
        tick();
        check("if_addr_c1",  32'(sram_addr), 32'd4);
        check("if_oe_n_c1",  32'(sram_oe_n), 32'd0);
        check("if_state_c1", 32'(fsm_state), 32'(INST));
        check("if_stall_c1", 32'(if_stall),  32'd1);
        tick();
        check("if_addr_c2",  32'(sram_addr), 32'd4);
        tick();
        check("if_ready_c3", 32'(if_ready),  32'd1);
        check("if_rdata_c3", if_rdata,       32'hE3A0_0001);
        check("if_stall_c3", 32'(if_stall),  32'd0);
        if_req = 1'b0;
        tick();
        check("if_ready_c4", 32'(if_ready),  32'd0);
        check("if_state_c4", 32'(fsm_state), 32'(IDLE));

        // Data and fetch requested together: data first, fetch behind it
        mem_rd_en = 1'b1; mem_addr = 32'h100; if_req = 1'b1; if_addr = 32'h104;
        for (int c = 0; c <= 7; c++) begin
            if (c == 1) check("both_state_c1", 32'(fsm_state), 32'(DATA));
            if (c == 3) begin
                check("both_mready_c3", 32'(mem_ready), 32'd1);
                check("both_mrdata_c3", mem_rdata,      32'hDEAD_BEEF);
                check("both_stall_c3",  32'(if_stall),  32'd1);
                mem_rd_en = 1'b0;
            end
            if (c == 4) check("both_state_c4", 32'(fsm_state), 32'(INST));
            if (c == 5) begin
                check("both_stall_c5",  32'(if_stall), 32'd1);
                check("both_iready_c5", 32'(if_ready), 32'd0);
            end
            if (c == 6) begin
                check("both_iready_c6", 32'(if_ready), 32'd1);
                check("both_irdata_c6", if_rdata,      32'h1234_5678);
                check("both_stall_c6",  32'(if_stall), 32'd0);
                if_req = 1'b0;
            end
            tick();
        end

        // Flush during a fetch, then refetch at the branch target
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        check("fl_state_c1", 32'(fsm_state), 32'(INST));
        if_flush = 1'b1; if_addr = 32'h10;
        tick();
        check("fl_state_c2", 32'(fsm_state), 32'(DISCARD));
        if_flush = 1'b0;
        tick();
        check("fl_iready_c3", 32'(if_ready),  32'd0);
        check("fl_irdata_c3", if_rdata,       32'h1234_5678);
        check("fl_state_c3",  32'(fsm_state), 32'(IDLE));
        tick();
        check("fl_state_c4",  32'(fsm_state), 32'(INST));
        check("fl_addr_c4",   32'(sram_addr), 32'd4);
        tick();
        tick();
        check("fl_iready_c6", 32'(if_ready),  32'd1);
        check("fl_irdata_c6", if_rdata,       32'hE3A0_0001);
        if_req = 1'b0;
        tick();

        // Asynchronous reset in the middle of a data read
        mem_rd_en = 1'b1; mem_addr = 32'h104;
        tick();
        check("rs_state_c1", 32'(fsm_state), 32'(DATA));
        check("rs_oe_n_c1",  32'(sram_oe_n), 32'd0);
        #2 rst = 1'b0;
        #1;
        check("rs_oe_n",      32'(sram_oe_n), 32'd1);
        check("rs_we_n",      32'(sram_we_n), 32'd1);
        check("rs_sram_addr", 32'(sram_addr), 32'd0);
        check("rs_wdata",     sram_wdata,     32'd0);
        check("rs_mready",    32'(mem_ready), 32'd0);
        check("rs_mrdata",    mem_rdata,      32'd0);
        check("rs_irdata",    if_rdata,       32'd0);
        check("rs_state",     32'(fsm_state), 32'(IDLE));
        check("rs_freeze",    32'(pipe_freeze), 32'd1);
        tick();
        tick();
        check("rs_mready_held", 32'(mem_ready), 32'd0);
        rst = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!mem_ready && lat < 10);
        check("rs_retry_lat",  32'(lat), 32'd3);
        check("rs_retry_data", mem_rdata, 32'h1234_5678);
        mem_rd_en = 1'b0;
        tick();
        check("rs_retry_once", 32'(mem_ready), 32'd0);

        // WAIT_CYCLES=1: fetch and load held together alternate one ready every 2 cycles
        b_mem_rd_en = 1'b1; b_mem_addr = 32'h200; d_exp_q.push_back(b_word(32'h200));
        b_if_req = 1'b1;    b_if_addr = 32'h1000; i_exp_q.push_back(b_word(32'h1000));
        d_done = 0; i_done = 0; last = -1;
        for (int c = 1; c <= 60 && (d_done < 6 || i_done < 6); c++) begin
            tick();
            if (b_mem_ready || b_if_ready) begin
                check("b_single_ready", 32'(b_mem_ready & b_if_ready), 32'd0);
                if (last >= 0) check("b_spacing", 32'(c - last), 32'd2);
                last = c;
            end
            if (b_mem_ready) begin
                check("b_d_queue", 32'(d_exp_q.size()), 32'd1);
                if (d_exp_q.size() > 0) check("b_mem_rdata", b_mem_rdata, d_exp_q.pop_front());
                d_done++;
                if (d_done < 6) begin
                    b_mem_addr = b_mem_addr + 32'd4;
                    d_exp_q.push_back(b_word(b_mem_addr));
                end else begin
                    b_mem_rd_en = 1'b0;
                end
            end
            if (b_if_ready) begin
                check("b_i_queue", 32'(i_exp_q.size()), 32'd1);
                if (i_exp_q.size() > 0) check("b_if_rdata", b_if_rdata, i_exp_q.pop_front());
                i_done++;
                if (i_done < 6) begin
                    b_if_addr = b_if_addr + 32'd4;
                    i_exp_q.push_back(b_word(b_if_addr));
                end else begin
                    b_if_req = 1'b0;
                end
            end
        end
        check("b_d_count", 32'(d_done), 32'd6);
        check("b_i_count", 32'(i_done), 32'd6);
        extra = 0;
        repeat (6) begin
            tick();
            if (b_mem_ready || b_if_ready) extra++;
        end
        check("b_no_extra_ready", 32'(extra), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported, fixed-latency external SRAM between the ARM pipeline's instruction fetch (IF stage) and data access (MEM stage). The arbiter serialises accesses, inserts the required SRAM wait states, and returns read data with a one-cycle ready pulse per requester. It also drives the pipeline-wide freeze for pending data accesses and the IF-local stall for pending fetches. It sits between IF_stage/MEM_stage and the SRAM pins, replacing their private memories.

## Interface
- WAIT_CYCLES, 2: SRAM access length in cycles (≥1).
- ADDR_W, 18: SRAM word-address width.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; level, held until if_ready.
- if_addr  in  32  fetch byte address.
- if_flush  in  1  branch taken; discard the in-flight fetch.
- if_rdata  out  32  instruction word; valid while if_ready.
- if_ready  out  1  one-cycle fetch completion pulse.
- if_stall  out  1  if_req & ~if_ready.
- mem_rd_en / mem_wr_en  in  1 / 1  data read / write request; level, held until mem_ready.
- mem_addr  in  32  data byte address.
- mem_wdata  in  32  store data.
- mem_rdata  out  32  load data; valid while mem_ready.
- mem_ready  out  1  one-cycle data completion pulse (reads and writes).
- pipe_freeze  out  1  (mem_rd_en | mem_wr_en) & ~mem_ready.
- sram_addr  out  ADDR_W  word address, registered.
- sram_wdata  out  32  write data, registered.
- sram_rdata  in  32  read data from SRAM.
- sram_we_n / sram_oe_n  out  1 / 1  write / output enable, active-low, registered.

## Operation
- States: IDLE, DATA, INST, DISCARD.
- IDLE arbitration, in cycles where FSM is IDLE:
  - Requesters whose ready is high this cycle are masked.
  - If a data request is present, grant DATA. Otherwise, if if_req & ~if_flush, grant INST.
  - Fixed priority: data over fetch.
- On grant:
  - Latch sram_addr = addr[ADDR_W+1:2]; low two address bits are ignored.
  - Latch sram_wdata and the operation.
  - Load wait counter with WAIT_CYCLES-1.
  - Reads: sram_oe_n=0. Writes: sram_we_n=0. Held for the whole access.
- In DATA/INST the counter decrements each cycle. On the edge where counter==0:
  - For reads, capture sram_rdata into the requester's rdata register.
  - Pulse that requester's ready.
  - Deassert the SRAM enables and return to IDLE.
- No preemption: a data request arriving during INST waits for that fetch to finish.
- if_flush seen during INST forces DISCARD. DISCARD completes the SRAM cycle normally but suppresses if_ready and leaves if_rdata unchanged. A flush in the if_ready cycle has no effect; that pulse already stands.
- if_flush in IDLE blocks the fetch grant that cycle.
- rdata registers hold their value until the next completion of the same requester.
- Simultaneous data read and write enables: treated as a write.

## Timing
- Request high in cycle 0 with FSM IDLE:
  - SRAM enables and address are driven cycles 1..WAIT_CYCLES.
  - Data is sampled at the end of cycle WAIT_CYCLES.
  - ready and rdata are valid in cycle WAIT_CYCLES+1.
- Back-to-back: the next grant occurs in the ready cycle, so consecutive accesses are spaced WAIT_CYCLES+1 cycles apart.
- Fetch behind data (both requested in cycle 0): mem_ready in cycle W+1, if_ready in cycle 2W+2.
- Reset (asynchronous, any state, including mid-access):
  - FSM→IDLE, counter 0.
  - sram_we_n=1, sram_oe_n=1, sram_addr=0, sram_wdata=0.
  - if_ready=0, mem_ready=0, if_rdata=0, mem_rdata=0.
  - The aborted access produces no ready pulse.
- if_stall and pipe_freeze are combinational from registered ready and input requests. There is no other combinational input→output path.

## Structure
- The shared package arm_mem_pkg holds:
  - the state enum (IDLE/DATA/INST/DISCARD);
  - the default WAIT_CYCLES and ADDR_W;
  - the op encoding (RD/WR).
- One sub-module: mem_wait_counter, a loadable down-counter with a zero flag, width $clog2(WAIT_CYCLES)+1.

## Test plan
- Reset release, if_req=1, if_addr=0x0000_0010, SRAM word 4 = 0xE3A0_0001, W=2 → sram_addr=4 in cycles 1–2; if_ready with if_rdata=0xE3A0_0001 in cycle 3; next fetch granted in cycle 3.
- Store: mem_wr_en=1, mem_addr=0x100, mem_wdata=0xDEAD_BEEF → sram_we_n=0 cycles 1–2 at addr 0x40; mem_ready in cycle 3; pipe_freeze high cycles 0–2. A following load from 0x100 returns 0xDEAD_BEEF.
- if_req and mem_rd_en both asserted in cycle 0 (W=2) → data served first (mem_ready cycle 3); if_ready in cycle 6; if_stall high cycles 0–5.
- if_flush pulsed in cycle 1 of a fetch → no if_ready pulse; if_rdata unchanged; FSM IDLE in cycle 3; a new fetch at the branch address is granted in cycle 3.
- rst driven low mid-DATA (cycle 1) → all outputs at reset values immediately; after release, a retried request completes normally with no stray ready.
- W=1 sweep with alternating fetch and load requests → ready every 2 cycles; rdata always matches the SRAM model; no requester is granted twice for one request.
